// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding,
// control-bit positions within m_ctl/wb_ctl, and the default WAIT timeout.
package mem_stage_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam int unsigned M_BRANCH    = 2;
  localparam int unsigned M_MEMREAD   = 1;
  localparam int unsigned M_MEMWRITE  = 0;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_mem_wb_register.sv
// MEM/WB pipeline register: a bubble clears valid and wb_ctl; read data is
// only overwritten when rdata_en marks a completing read.
module MEM_WB_register (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [1:0]  wb_ctl_d,
  input  logic        rdata_en,
  input  logic [31:0] rdata_d,
  input  logic [31:0] alu_result_d,
  input  logic [4:0]  wreg_d,
  output logic        valid,
  output logic [1:0]  wb_ctl,
  output logic [31:0] rdata,
  output logic [31:0] alu_result,
  output logic [4:0]  wreg
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      wb_ctl     <= '0;
      rdata      <= '0;
      alu_result <= '0;
      wreg       <= '0;
    end else begin
      valid  <= load_valid;
      wb_ctl <= load_valid ? wb_ctl_d : 2'b00;
      if (load_valid) begin
        alu_result <= alu_result_d;
        wreg       <= wreg_d;
      end
      if (rdata_en) begin
        rdata <= rdata_d;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls until ack or timeout,
// resolves branches and feeds MEM/WB. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [1:0]               in_wb_ctl,
  input  logic [2:0]               in_m_ctl,
  input  logic [31:0]              in_add_result,
  input  logic                     in_zero,
  input  logic [31:0]              in_alu_result,
  input  logic [31:0]              in_rdata2,
  input  logic [4:0]               in_wreg,
  output logic                     stall,
  output logic                     pcsrc,
  output logic [31:0]              branch_target,
  mem_access_stage_if.master       dmem,
  output logic                     mem_wb_valid,
  output logic [1:0]               mem_wb_wb_ctl,
  output logic [31:0]              mem_wb_rdata,
  output logic [31:0]              mem_wb_alu_result,
  output logic [4:0]               mem_wb_wreg,
  output logic                     mem_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            req_we;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;

  logic            memread, memwrite, is_mem, misalign, access;
  logic            req_c, we_c;
  logic [31:0]     addr_c, wdata_c;
  logic            timeout_now, complete;
  logic [1:0]      wb_eff;
  logic            wb_load_valid, wb_rdata_en;

  assign memread  = in_m_ctl[M_MEMREAD];
  assign memwrite = in_m_ctl[M_MEMWRITE];
  assign is_mem   = in_valid & (memread | memwrite);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem & (in_alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign access = is_mem & ~misalign;

  // In WAIT the bus is driven from the copies captured at issue, so memory
  // sees a stable request regardless of what the inputs do.
  always_comb begin
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    if (state == S_WAIT) begin
      req_c   = 1'b1;
      we_c    = req_we;
      addr_c  = req_addr;
      wdata_c = req_wdata;
    end else if (access) begin
      req_c   = 1'b1;
      we_c    = memwrite;
      addr_c  = in_alu_result;
      wdata_c = in_rdata2;
    end
  end

  always_comb begin
    wb_eff = in_wb_ctl;
    if (memread & memwrite) begin
      wb_eff[WB_REGWRITE] = 1'b0;
    end
  end

  assign timeout_now = (state == S_WAIT) && (cnt == CW'(TIMEOUT - 1)) && !dmem.dmem_ack;
  assign complete    = req_c & dmem.dmem_ack;

  // Stall drops in the timeout cycle so upstream advances on the abort edge.
  assign stall = rst_n & req_c & ~dmem.dmem_ack & ~timeout_now;

  assign dmem.dmem_req   = rst_n & req_c;
  assign dmem.dmem_we    = rst_n & we_c;
  assign dmem.dmem_addr  = rst_n ? addr_c  : '0;
  assign dmem.dmem_wdata = rst_n ? wdata_c : '0;

  assign pcsrc         = rst_n & in_valid & in_m_ctl[M_BRANCH] & in_zero;
  assign branch_target = rst_n ? in_add_result : '0;

  assign wb_load_valid = complete | ((state == S_IDLE) & in_valid & ~is_mem);
  assign wb_rdata_en   = complete & ~we_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      mem_err <= timeout_now | ((state == S_IDLE) & misalign);
      case (state)
        S_IDLE: begin
          if (access && !dmem.dmem_ack) begin
            state     <= S_WAIT;
            cnt       <= '0;
            req_we    <= memwrite;
            req_addr  <= in_alu_result;
            req_wdata <= in_rdata2;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_ack || timeout_now) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  MEM_WB_register u_mem_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (wb_load_valid),
    .wb_ctl_d     (wb_eff),
    .rdata_en     (wb_rdata_en),
    .rdata_d      (dmem.dmem_rdata),
    .alu_result_d (in_alu_result),
    .wreg_d       (in_wreg),
    .valid        (mem_wb_valid),
    .wb_ctl       (mem_wb_wb_ctl),
    .rdata        (mem_wb_rdata),
    .alu_result   (mem_wb_alu_result),
    .wreg         (mem_wb_wreg)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT = 16).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_wb_ctl;
  logic [2:0]  in_m_ctl;
  logic [31:0] in_add_result;
  logic        in_zero;
  logic [31:0] in_alu_result;
  logic [31:0] in_rdata2;
  logic [4:0]  in_wreg;
  logic        stall, pcsrc, mem_err;
  logic [31:0] branch_target;
  logic        mem_wb_valid;
  logic [1:0]  mem_wb_wb_ctl;
  logic [31:0] mem_wb_rdata, mem_wb_alu_result;
  logic [4:0]  mem_wb_wreg;

  int checks   = 0;
  int failures = 0;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_wb_ctl         (in_wb_ctl),
    .in_m_ctl          (in_m_ctl),
    .in_add_result     (in_add_result),
    .in_zero           (in_zero),
    .in_alu_result     (in_alu_result),
    .in_rdata2         (in_rdata2),
    .in_wreg           (in_wreg),
    .stall             (stall),
    .pcsrc             (pcsrc),
    .branch_target     (branch_target),
    .dmem              (dmem_bus.master),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_wb_ctl     (mem_wb_wb_ctl),
    .mem_wb_rdata      (mem_wb_rdata),
    .mem_wb_alu_result (mem_wb_alu_result),
    .mem_wb_wreg       (mem_wb_wreg),
    .mem_err           (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    in_valid      = v;
    in_wb_ctl     = wb;
    in_m_ctl      = m;
    in_alu_result = alu;
    in_rdata2     = wd;
    in_wreg       = wr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=0x%08h exp=0x%08h", 32'd0, 32'd1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;
    int errs;
    logic done;

    rst_n = 1'b0;
    drive(1'b1, 2'b11, 3'b110, 32'h10, 32'h99, 5'd3);
    in_zero = 1'b1;
    in_add_result = 32'h400;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall",   stall, 0);
    check_eq("rst_req",     dmem_bus.dmem_req, 0);
    check_eq("rst_addr",    dmem_bus.dmem_addr, 0);
    check_eq("rst_wdata",   dmem_bus.dmem_wdata, 0);
    check_eq("rst_pcsrc",   pcsrc, 0);
    check_eq("rst_target",  branch_target, 0);
    check_eq("rst_wb_valid", mem_wb_valid, 0);
    check_eq("rst_wb_rdata", mem_wb_rdata, 0);
    check_eq("rst_mem_err", mem_err, 0);

    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    in_zero = 1'b0;
    #1 rst_n = 1'b1;
    step();

    // Load at 0x10, ack on the 4th cycle -> three stall cycles
    drive(1'b1, 2'b11, 3'b010, 32'h10, 32'h0, 5'd5);
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'hDEADBEEF;
      end
      #1;
      if (stall) stalls++;
      if (k == 0) begin
        check_eq("load_req", dmem_bus.dmem_req, 1);
        check_eq("load_we",  dmem_bus.dmem_we, 0);
      end
      if (k == 1) check_eq("load_wait_addr", dmem_bus.dmem_addr, 32'h10);
      step();
    end
    dmem_bus.dmem_ack = 1'b0;
    check_eq("load_stall_cycles", stalls, 3);
    check_eq("load_wb_valid", mem_wb_valid, 1);
    check_eq("load_wb_rdata", mem_wb_rdata, 32'hDEADBEEF);
    check_eq("load_wb_ctl",   mem_wb_wb_ctl, 2'b11);
    check_eq("load_wb_wreg",  mem_wb_wreg, 5);
    check_eq("load_wb_alu",   mem_wb_alu_result, 32'h10);

    // Store 0x1234 to 0x20, same-cycle ack
    drive(1'b1, 2'b01, 3'b001, 32'h20, 32'h1234, 5'd6);
    dmem_bus.dmem_ack = 1'b1;
    #1;
    check_eq("store_req",   dmem_bus.dmem_req, 1);
    check_eq("store_we",    dmem_bus.dmem_we, 1);
    check_eq("store_addr",  dmem_bus.dmem_addr, 32'h20);
    check_eq("store_wdata", dmem_bus.dmem_wdata, 32'h1234);
    check_eq("store_stall", stall, 0);
    step();
    dmem_bus.dmem_ack = 1'b0;
    check_eq("store_wb_valid", mem_wb_valid, 1);
    check_eq("store_wb_ctl",   mem_wb_wb_ctl, 2'b01);
    check_eq("store_rdata_held", mem_wb_rdata, 32'hDEADBEEF);

    // memread and memwrite both set -> write, regwrite cleared
    drive(1'b1, 2'b11, 3'b011, 32'h24, 32'h77, 5'd7);
    dmem_bus.dmem_ack = 1'b1;
    #1;
    check_eq("both_we", dmem_bus.dmem_we, 1);
    step();
    dmem_bus.dmem_ack = 1'b0;
    check_eq("both_wb_ctl", mem_wb_wb_ctl, 2'b01);

    // Non-memory instruction, latency 1
    drive(1'b1, 2'b10, 3'b000, 32'h55, 32'h0, 5'd9);
    #1;
    check_eq("alu_stall", stall, 0);
    check_eq("alu_req",   dmem_bus.dmem_req, 0);
    step();
    check_eq("alu_wb_valid", mem_wb_valid, 1);
    check_eq("alu_wb_alu",   mem_wb_alu_result, 32'h55);
    check_eq("alu_wb_wreg",  mem_wb_wreg, 9);
    check_eq("alu_wb_ctl",   mem_wb_wb_ctl, 2'b10);

    // Bubble with a stray ack
    drive(1'b0, 2'b11, 3'b010, 32'h60, 32'h0, 5'd1);
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'h00000BAD;
    #1;
    check_eq("bubble_req",   dmem_bus.dmem_req, 0);
    check_eq("bubble_stall", stall, 0);
    step();
    dmem_bus.dmem_ack = 1'b0;
    check_eq("bubble_wb_valid", mem_wb_valid, 0);
    check_eq("bubble_wb_ctl",   mem_wb_wb_ctl, 0);
    check_eq("bubble_rdata",    mem_wb_rdata, 32'hDEADBEEF);

    // Branch resolution
    drive(1'b1, 2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
    in_zero = 1'b1;
    in_add_result = 32'h400;
    #1;
    check_eq("br_taken",  pcsrc, 1);
    check_eq("br_target", branch_target, 32'h400);
    in_zero = 1'b0;
    #1;
    check_eq("br_not_taken", pcsrc, 0);
    in_zero = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("br_bubble", pcsrc, 0);
    in_zero = 1'b0;
    step();

    // Timeout: no ack ever arrives
    drive(1'b1, 2'b11, 3'b010, 32'h30, 32'h0, 5'd4);
    stalls = 0;
    errs = 0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall) stalls++;
      else done = 1'b1;
      step();
      if (mem_err) errs++;
      if (done) break;
    end
    check_eq("to_bound", done, 1);
    check_eq("to_stall_cycles", stalls, 16);
    check_eq("to_mem_err", mem_err, 1);
    check_eq("to_wb_valid", mem_wb_valid, 0);
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    #1;
    check_eq("to_stall_released", stall, 0);
    step();
    check_eq("to_err_once", mem_err, 0);
    check_eq("to_err_count", errs, 1);

    // Ack arriving in the timeout cycle wins
    drive(1'b1, 2'b10, 3'b010, 32'h34, 32'h0, 5'd8);
    repeat (16) step();
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'hCAFE0001;
    #1;
    check_eq("race_req",   dmem_bus.dmem_req, 1);
    check_eq("race_stall", stall, 0);
    step();
    dmem_bus.dmem_ack = 1'b0;
    check_eq("race_no_err",   mem_err, 0);
    check_eq("race_wb_valid", mem_wb_valid, 1);
    check_eq("race_wb_rdata", mem_wb_rdata, 32'hCAFE0001);
    check_eq("race_wb_wreg",  mem_wb_wreg, 8);

    // Reset asserted while in WAIT
    drive(1'b1, 2'b10, 3'b010, 32'h40, 32'h0, 5'd2);
    step();
    step();
    #1;
    check_eq("rw_pre_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rw_req",      dmem_bus.dmem_req, 0);
    check_eq("rw_addr",     dmem_bus.dmem_addr, 0);
    check_eq("rw_stall",    stall, 0);
    check_eq("rw_wb_rdata", mem_wb_rdata, 0);
    check_eq("rw_wb_ctl",   mem_wb_wb_ctl, 0);
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    #1 rst_n = 1'b1;
    drive(1'b1, 2'b10, 3'b000, 32'h66, 32'h0, 5'd2);
    #1;
    check_eq("rw_idle_stall", stall, 0);
    step();
    check_eq("rw_wb_valid", mem_wb_valid, 1);
    check_eq("rw_wb_alu",   mem_wb_alu_result, 32'h66);

    // Unaligned load at 0x13
    drive(1'b1, 2'b11, 3'b010, 32'h13, 32'h0, 5'd3);
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    check_eq("mis_req",   dmem_bus.dmem_req, 0);
    check_eq("mis_stall", stall, 0);
    step();
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    check_eq("mis_err",      mem_err, 1);
    check_eq("mis_wb_valid", mem_wb_valid, 0);
    step();
    check_eq("mis_err_once", mem_err, 0);
`else
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'h13131313;
    #1;
    check_eq("mis_req",  dmem_bus.dmem_req, 1);
    check_eq("mis_addr", dmem_bus.dmem_addr, 32'h13);
    step();
    dmem_bus.dmem_ack = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    check_eq("mis_wb_valid", mem_wb_valid, 1);
    check_eq("mis_wb_rdata", mem_wb_rdata, 32'h13131313);
    check_eq("mis_no_err",   mem_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
